// File: rtl/writeback_regfile_pkg.sv
// rtl/writeback_regfile_pkg.sv - shared widths and constants for the write-back register bank
package writeback_regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 2;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [CNT_W-1:0]  CNT_MAX  = 2'd3;

endpackage

// File: rtl/writeback_regfile_pending_counter.sv
// rtl/writeback_regfile_pending_counter.sv - saturating in-flight producer counter for one register
module pending_counter #(
  parameter int CNT_W = writeback_regfile_pkg::CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic clear,
  output logic nonzero,
  output logic is_one,
  output logic overflow,
  output logic underflow
);

  localparam logic [CNT_W-1:0] CNT_TOP = '1;

  logic [CNT_W-1:0] cnt;
  logic             up;
  logic             down;

  // An issue and a retirement on the same edge cancel; clear overrides both.
  assign up   = inc & ~dec & ~clear;
  assign down = dec & ~inc & ~clear;

  assign overflow  = up && (cnt == CNT_TOP);
  assign underflow = down && (cnt == '0);
  assign nonzero   = (cnt != '0);
  assign is_one    = (cnt == CNT_W'(1));

  // Count moves one step per edge and holds at either end instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (up && !overflow) begin
      cnt <= cnt + 1'b1;
    end else if (down && !underflow) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - register bank with write-back bypass and pending-write scoreboard
module writeback_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              flush,
  output logic              busy_a,
  output logic              busy_b,
  output logic              sb_err
);

  import writeback_regfile_pkg::*;

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   nonzero;
  logic [NREG-1:0]   is_one;
  logic [NREG-1:0]   ovf;
  logic [NREG-1:0]   unf;
  logic              wb_hit;
  logic              iss_hit;

  // Register 0 is hard-wired: neither writes nor issues to it do anything.
  assign wb_hit  = wb_en && (wb_addr != REG_ZERO);
  assign iss_hit = iss_en && (iss_addr != REG_ZERO);

  // Register storage; entry 0 is never written so it always reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_hit) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign nonzero[0] = 1'b0;
  assign is_one[0]  = 1'b0;
  assign ovf[0]     = 1'b0;
  assign unf[0]     = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    pending_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (iss_hit && (iss_addr == ADDR_W'(r))),
      .dec       (wb_hit && (wb_addr == ADDR_W'(r))),
      .clear     (flush),
      .nonzero   (nonzero[r]),
      .is_one    (is_one[r]),
      .overflow  (ovf[r]),
      .underflow (unf[r])
    );
  end

  // Any counter saturating or an orphan write-back latches the error until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_err <= 1'b0;
    end else if (|(ovf | unf)) begin
      sb_err <= 1'b1;
    end
  end

  // Port A read: bypass the in-flight write-back, hold zero during reset.
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    busy_a    = nonzero[rd_addr_a];
    if (wb_hit && (wb_addr == rd_addr_a)) begin
      rd_data_a = wb_data;
      if (is_one[rd_addr_a]) busy_a = 1'b0;
    end
    if (rst) begin
      rd_data_a = '0;
      busy_a    = 1'b0;
    end
  end

  // Port B read: same bypass and last-producer retirement rule as port A.
  always_comb begin
    rd_data_b = regs[rd_addr_b];
    busy_b    = nonzero[rd_addr_b];
    if (wb_hit && (wb_addr == rd_addr_b)) begin
      rd_data_b = wb_data;
      if (is_one[rd_addr_b]) busy_b = 1'b0;
    end
    if (rst) begin
      rd_data_b = '0;
      busy_b    = 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - directed vector bench for writeback_regfile
module tb_writeback_regfile;

  logic        clk;
  logic        rst;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        flush;
  logic        busy_a;
  logic        busy_b;
  logic        sb_err;

  int checks;
  int errors;

  writeback_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .flush     (flush),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .sb_err    (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v_wb_en;
    logic [4:0]  v_wb_addr;
    logic [31:0] v_wb_data;
    logic        v_iss_en;
    logic [4:0]  v_iss_addr;
    logic        v_flush;
    logic [4:0]  v_ra;
    logic [4:0]  v_rb;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic        e_busy_a;
    logic        e_busy_b;
    logic        e_err;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ia, input logic fl,
                       input logic [4:0] ra, input logic [4:0] rb);
    wb_en = we; wb_addr = wa; wb_data = wd;
    iss_en = ie; iss_addr = ia; flush = fl;
    rd_addr_a = ra; rd_addr_b = rb;
  endtask

  task automatic check_outs(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                            input logic eba, input logic ebb, input logic ee);
    check({tag, " rd_data_a"}, rd_data_a, ea);
    check({tag, " rd_data_b"}, rd_data_b, eb);
    check({tag, " busy_a"}, {31'd0, busy_a}, {31'd0, eba});
    check({tag, " busy_b"}, {31'd0, busy_b}, {31'd0, ebb});
    check({tag, " sb_err"}, {31'd0, sb_err}, {31'd0, ee});
  endtask

  task automatic idle_step(input logic [4:0] ra, input logic [4:0] rb);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, ra, rb);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);

    //            wb_en wb_addr wb_data        iss   iss_a  flush ra     rb     exp_a          exp_b          ba    bb    err
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd5,  5'd31, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b0, 5'd7,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd7,  5'd5,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 5'd0,  32'h1234,     1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  5'd7,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd3,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd3,  5'd0,  32'h0,        32'h0,        1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 5'd3,  32'h33,       1'b0, 5'd0,  1'b0, 5'd3,  5'd7,  32'h33,       32'hDEADBEEF, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 5'd3,  32'h44,       1'b0, 5'd0,  1'b0, 5'd3,  5'd3,  32'h44,       32'h44,       1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd3,  5'd9,  32'h44,       32'h0,        1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd9,  5'd3,  32'h0,        32'h44,       1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd9,  5'd3,  32'h0,        32'h44,       1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd9,  5'd3,  32'h0,        32'h44,       1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd9,  5'd3,  32'h0,        32'h44,       1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd9,  5'd3,  32'h0,        32'h44,       1'b1, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 5'd9,  32'h91,       1'b0, 5'd0,  1'b0, 5'd9,  5'd9,  32'h91,       32'h91,       1'b1, 1'b1, 1'b1};
    vecs[17] = '{1'b1, 5'd9,  32'h92,       1'b0, 5'd0,  1'b0, 5'd9,  5'd0,  32'h92,       32'h0,        1'b1, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd9,  5'd0,  32'h92,       32'h0,        1'b1, 1'b0, 1'b1};
    vecs[19] = '{1'b1, 5'd9,  32'h93,       1'b0, 5'd0,  1'b0, 5'd9,  5'd9,  32'h93,       32'h93,       1'b0, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd9,  5'd9,  32'h93,       32'h93,       1'b0, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table: each vector is checked before the edge that commits it.
    for (int i = 0; i < 21; i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i].v_wb_en, vecs[i].v_wb_addr, vecs[i].v_wb_data, vecs[i].v_iss_en,
            vecs[i].v_iss_addr, vecs[i].v_flush, vecs[i].v_ra, vecs[i].v_rb);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].e_a, vecs[i].e_b,
                 vecs[i].e_busy_a, vecs[i].e_busy_b, vecs[i].e_err);
    end

    // Asynchronous reset mid-cycle: state and bypass clear immediately.
    @(negedge clk);
    drive(1'b1, 5'd4, 32'h99, 1'b1, 5'd9, 1'b0, 5'd4, 5'd9);
    #1;
    rst = 1'b1;
    #1;
    check_outs("rst_async", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle_step(5'd4, 5'd7);
    rst = 1'b0;
    #1;
    check_outs("rst_after", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Orphan write-back at count 0: error sets, data still stored.
    @(negedge clk);
    drive(1'b1, 5'd10, 32'hA5, 1'b0, 5'd0, 1'b0, 5'd10, 5'd0);
    #1;
    check_outs("orphan_pre", 32'hA5, 32'h0, 1'b0, 1'b0, 1'b0);
    idle_step(5'd10, 5'd0);
    #1;
    check_outs("orphan_post", 32'hA5, 32'h0, 1'b0, 1'b0, 1'b1);

    // Flush with a concurrent write-back: counts clear, data lands.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd4, 5'd6);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b0, 5'd4, 5'd6);
    #1;
    check_outs("flush_iss", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'd4, 32'h55, 1'b0, 5'd0, 1'b1, 5'd4, 5'd6);
    #1;
    check_outs("flush_pre", 32'h55, 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b1, 5'd4, 5'd6);
    #1;
    check_outs("flush_post", 32'h55, 32'h0, 1'b0, 1'b0, 1'b0);
    idle_step(5'd6, 5'd4);
    #1;
    check_outs("flush_over_iss", 32'h0, 32'h55, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Receiving end of the write-back pipeline buffer: a 32 × 32-bit register bank that takes the buffered write-back destination, data and enable, and serves two combinational read ports to decode. Same-cycle write-to-read bypass lets decode see a value in the cycle it is written back. A per-register pending-write scoreboard tracks up to three in-flight producers. It raises `busy_a`/`busy_b` so the hazard logic can stall instead of reading stale data.

## Interface
Parameters:
- `DATA_W`, 32, register and data width
- `ADDR_W`, 5, register index width (32 registers)
- `CNT_W`, 2, pending-write counter width per register (saturates at 3)

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `wb_en`  in  1  write-back enable from the write-back buffer
- `wb_addr`  in  ADDR_W  write-back destination register
- `wb_data`  in  DATA_W  write-back data (memory or ALU result already selected)
- `rd_addr_a`, `rd_addr_b`  in  ADDR_W  decode read indices
- `rd_data_a`, `rd_data_b`  out  DATA_W  read data, combinational
- `iss_en`  in  1  an instruction writing `iss_addr` leaves decode this cycle
- `iss_addr`  in  ADDR_W  destination of the issuing instruction
- `flush`  in  1  pipeline flush; discards all pending counts
- `busy_a`, `busy_b`  out  1  the read register still has an unretired producer
- `sb_err`  out  1  sticky scoreboard error (overflow or orphan write-back)

## Operation
- Reset (asynchronous, immediate): all 32 registers = 0, all counters = 0, `sb_err` = 0. As a result, `rd_data_*` = 0 and `busy_*` = 0 while `rst` is high.
- Register 0: writes ignored, reads return 0, counter never changes, never busy. `iss_en` or `wb_en` targeting 0 has no effect and never sets `sb_err`.
- Write: at a rising edge with `wb_en` = 1 and `wb_addr` ≠ 0, the register takes `wb_data`.
- Read: `rd_data_x` = `wb_data` when `wb_en` = 1, `wb_addr` = `rd_addr_x` and the address ≠ 0 (bypass). Otherwise it is the stored value.
- Counter update per register r ≠ 0 at each edge, unless `flush` is asserted:
  - issue only: +1
  - write-back only: −1
  - both on the same r: unchanged
- Boundary conditions:
  - issue only at count 3: count stays 3, `sb_err` is set.
  - write-back only at count 0: count stays 0, `sb_err` is set. The data write still occurs.
- `flush` = 1: all counters go to 0 at the edge, overriding issue and write-back counting. A data write in the same cycle still happens.
- `busy_x` = (count[rd_addr_x] ≠ 0), except it is forced to 0 when `wb_en` = 1, `wb_addr` = `rd_addr_x` and count = 1. In that case the last producer retires this cycle and the bypass supplies its value.
- `sb_err` stays set until `rst`.

## Timing
- Write latency: the value is stored at the first rising edge with `wb_en`. It is visible combinationally in the same cycle through the bypass.
- Read latency: 0 cycles (combinational from addresses and the write-back inputs).
- Scoreboard: `busy` reflects an issue from the cycle after the `iss_en` edge. It reflects a write-back retirement in the same cycle (bypass rule).
- Reset mid-operation: all state clears immediately. Inputs during `rst` are ignored. Normal operation resumes at the first edge after `rst` falls.

## Structure
- Shared package: `DATA_W`, `ADDR_W`, `CNT_W`, `REG_ZERO` = 5'd0, `CNT_MAX` = 2'd3.
- Sub-module `pending_counter`: 2-bit saturating up/down counter with inc, dec, clear, `clk` and `rst`. Outputs are `nonzero`, `is_one`, `overflow` and `underflow`. It is instantiated once for each of registers 1–31.
- Top level: register array, two read/bypass muxes, the busy logic, and the sticky OR of the counter error strobes.

## Test plan
- Reset, then read registers 5 and 31 → `rd_data` = 0, `busy` = 0, `sb_err` = 0.
- Write 0xDEADBEEF to r7 with `rd_addr_a` = 7 in the same cycle → `rd_data_a` = 0xDEADBEEF before the edge (bypass). The stored value is 0xDEADBEEF after the edge.
- Write 0x1234 to r0 and issue to r0 → `rd_data` of r0 = 0, `busy` = 0, `sb_err` = 0.
- Issue r3 twice, then write back r3 → `busy` is 1 after the first issue and stays 1 after the first write-back (count 2→1). On the second write-back, `busy_a` drops to 0 in that same cycle.
- Issue r9 four times → the count saturates at 3 and `sb_err` = 1. A write-back to r10 at count 0 also sets `sb_err`, and the r10 data is still written.
- Issue r4 and r6, then assert `flush` together with a write-back of 0x55 to r4 → all `busy` = 0 after the edge, and r4 = 0x55. Asserting `rst` mid-sequence clears all registers immediately.
